// File: rtl/io_port_ctrl.sv
// Memory-mapped user-I/O responder: captures the keypad operand on a debounced
// enter press and exposes result/status registers on the CPU data bus.
module io_port_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_F000,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        enter,
  input  logic [31:0] data_show_i,
  output logic [31:0] data_show_o,
  output logic        out_o,
  output logic        int_o
);

  localparam logic [1:0] IDX_IN_DATA  = 2'd0;
  localparam logic [1:0] IDX_STATUS   = 2'd1;
  localparam logic [1:0] IDX_OUT_DATA = 2'd2;
  localparam logic [1:0] IDX_CTRL     = 2'd3;
  localparam logic [7:0] CNT_LAST     = 8'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic        deb_q, deb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        press;

  logic [31:0] in_data_q, in_data_d;
  logic        in_valid_q, in_valid_d;
  logic        overrun_q, overrun_d;
  logic        ie_q, ie_d;
  logic        out_q, out_d;
  logic [31:0] show_q, show_d;
  logic        int_q, int_d;

  logic        hit, rd, wr, rd_in, wr_ctrl;
  logic [1:0]  idx;
  logic        unused_addr_lsb;

  assign hit     = ce_i && (addr_i[31:4] == BASE_ADDR[31:4]);
  assign idx     = addr_i[3:2];
  assign rd      = hit && !we_i;
  assign wr      = hit && we_i;
  assign rd_in   = rd && (idx == IDX_IN_DATA);
  assign wr_ctrl = wr && (idx == IDX_CTRL) && sel_i[0];
  assign unused_addr_lsb = ^addr_i[1:0];

  always_comb begin
    data_o = 32'h0;
    if (rd) begin
      case (idx)
        IDX_IN_DATA:  data_o = in_data_q;
        IDX_STATUS:   data_o = {28'h0, ie_q, out_q, overrun_q, in_valid_q};
        IDX_OUT_DATA: data_o = show_q;
        default:      data_o = 32'h0;
      endcase
    end
  end

  // Debouncer: count consecutive cycles the synced level disagrees with the accepted level
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    press = 1'b0;
    if (sync2_q == deb_q) begin
      cnt_d = 8'h0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = ~deb_q;
      cnt_d = 8'h0;
      press = ~deb_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    in_data_d  = in_data_q;
    in_valid_d = in_valid_q;
    overrun_d  = overrun_q;
    ie_d       = ie_q;
    out_d      = out_q;
    show_d     = show_q;
    int_d      = in_valid_q & ie_q;

    if (rd_in) begin
      in_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    if (wr && (idx == IDX_OUT_DATA)) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) show_d[8*b +: 8] = data_i[8*b +: 8];
      end
      out_d = 1'b1;
    end

    if (wr_ctrl) begin
      if (data_i[0]) out_d = 1'b0;
      if (data_i[1]) overrun_d = 1'b0;
      ie_d = data_i[2];
    end

    // A press overrides any same-cycle clear; overrun only if the old value survives unread
    if (press) begin
      in_data_d  = data_show_i;
      in_valid_d = 1'b1;
      if (in_valid_q && !rd_in) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      cnt_q      <= 8'h0;
      in_data_q  <= 32'h0;
      in_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ie_q       <= 1'b0;
      out_q      <= 1'b0;
      show_q     <= 32'h0;
      int_q      <= 1'b0;
    end else begin
      sync1_q    <= enter;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      overrun_q  <= overrun_d;
      ie_q       <= ie_d;
      out_q      <= out_d;
      show_q     <= show_d;
      int_q      <= int_d;
    end
  end

  assign data_show_o = show_q;
  assign out_o       = out_q;
  assign int_o       = int_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: register map, enter debounce timing,
// overrun/read races, interrupt timing and out-of-window accesses.
module tb_io_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [3:0]  sel_i = 4'h0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        enter = 1'b0;
  logic [31:0] data_show_i = 32'h0;
  logic [31:0] data_show_o;
  logic        out_o;
  logic        int_o;

  int vectors = 0;
  int errors  = 0;

  io_port_ctrl #(.BASE_ADDR(32'h0000_F000), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .enter(enter),
    .data_show_i(data_show_i), .data_show_o(data_show_o), .out_o(out_o),
    .int_o(int_o)
  );

  always #5 clk = ~clk;

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a; sel_i = 4'hF;
    #1 d = data_o;
    @(negedge clk);
    ce_i = 1'b0;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = v; sel_i = s;
    @(negedge clk);
    ce_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic press_key(input logic [31:0] v);
    data_show_i = v;
    @(negedge clk);
    enter = 1'b1;
    repeat (9) @(negedge clk);
    enter = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b0;
    #12;
    vectors++;
    if (data_show_o !== 32'h0) begin errors++; $display("FAIL reset_show: got %h want %h", data_show_o, 32'h0); end
    vectors++;
    if (out_o !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", out_o); end
    vectors++;
    if (int_o !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", int_o); end
    @(negedge clk);
    rst = 1'b1;
    read_reg(32'h0000_F004, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want %h", d, 32'h0); end
    read_reg(32'h0000_F000, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_in_data: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_press;
    logic [31:0] d;
    data_show_i = 32'h0000_0025;
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_F004; sel_i = 4'hF;
    enter = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        vectors++;
        if (data_o[0] !== 1'b0) begin errors++; $display("FAIL press_early: got %b want 0 after 5 edges", data_o[0]); end
      end
      if (i == 6) begin
        vectors++;
        if (data_o[0] !== 1'b1) begin errors++; $display("FAIL press_latency: got %b want 1 after 6 edges", data_o[0]); end
      end
    end
    ce_i = 1'b0;
    repeat (4) @(negedge clk);
    enter = 1'b0;
    repeat (9) @(negedge clk);
    read_reg(32'h0000_F000, d);
    vectors++;
    if (d !== 32'h0000_0025) begin errors++; $display("FAIL press_data: got %h want %h", d, 32'h25); end
    read_reg(32'h0000_F004, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL press_status_clr: got %h want %h", d, 32'h0); end
    vectors++;
    if (int_o !== 1'b0) begin errors++; $display("FAIL press_int_masked: got %b want 0", int_o); end
  endtask

  task automatic test_out_data;
    logic [31:0] d;
    write_reg(32'h0000_F008, 32'h1234_5678, 4'b1111);
    vectors++;
    if (data_show_o !== 32'h1234_5678) begin errors++; $display("FAIL out_full: got %h want %h", data_show_o, 32'h12345678); end
    vectors++;
    if (out_o !== 1'b1) begin errors++; $display("FAIL out_set: got %b want 1", out_o); end
    read_reg(32'h0000_F004, d);
    vectors++;
    if (d !== 32'h4) begin errors++; $display("FAIL out_status: got %h want %h", d, 32'h4); end
    write_reg(32'h0000_F008, 32'hFFFF_FFFF, 4'b0001);
    vectors++;
    if (data_show_o !== 32'h1234_56FF) begin errors++; $display("FAIL out_byte0: got %h want %h", data_show_o, 32'h123456FF); end
    write_reg(32'h0000_F00C, 32'h0000_0001, 4'b1110);
    vectors++;
    if (out_o !== 1'b1) begin errors++; $display("FAIL ctrl_sel0_gate: got %b want 1", out_o); end
    read_reg(32'h0000_F008, d);
    vectors++;
    if (d !== 32'h1234_56FF) begin errors++; $display("FAIL out_readback: got %h want %h", d, 32'h123456FF); end
    write_reg(32'h0000_F00C, 32'h0000_0001, 4'b1111);
    vectors++;
    if (out_o !== 1'b0) begin errors++; $display("FAIL out_clear: got %b want 0", out_o); end
    read_reg(32'h0000_F00C, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL ctrl_reads0: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    press_key(32'h0000_0011);
    press_key(32'h0000_0022);
    read_reg(32'h0000_F004, d);
    vectors++;
    if (d !== 32'h3) begin errors++; $display("FAIL overrun_status: got %h want %h", d, 32'h3); end
    data_show_i = 32'h0000_0033;
    @(negedge clk);
    enter = 1'b1;
    repeat (5) @(negedge clk);
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_F000; sel_i = 4'hF;
    #1;
    vectors++;
    if (data_o !== 32'h0000_0022) begin errors++; $display("FAIL race_old_data: got %h want %h", data_o, 32'h22); end
    @(negedge clk);
    ce_i = 1'b0;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    repeat (9) @(negedge clk);
    read_reg(32'h0000_F004, d);
    vectors++;
    if (d !== 32'h1) begin errors++; $display("FAIL race_status: got %h want %h", d, 32'h1); end
    read_reg(32'h0000_F000, d);
    vectors++;
    if (d !== 32'h0000_0033) begin errors++; $display("FAIL race_new_data: got %h want %h", d, 32'h33); end
  endtask

  task automatic test_glitch_int;
    logic [31:0] d;
    data_show_i = 32'h0000_0099;
    @(negedge clk);
    enter = 1'b1;
    repeat (2) @(negedge clk);
    enter = 1'b0;
    repeat (10) @(negedge clk);
    read_reg(32'h0000_F004, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_status: got %h want %h", d, 32'h0); end
    write_reg(32'h0000_F00C, 32'h0000_0004, 4'b1111);
    data_show_i = 32'h0000_0044;
    @(negedge clk);
    enter = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if (int_o !== 1'b0) begin errors++; $display("FAIL int_early: got %b want 0", int_o); end
    @(negedge clk);
    vectors++;
    if (int_o !== 1'b1) begin errors++; $display("FAIL int_rise: got %b want 1", int_o); end
    repeat (2) @(negedge clk);
    enter = 1'b0;
    repeat (9) @(negedge clk);
    read_reg(32'h0000_F004, d);
    vectors++;
    if (d !== 32'h9) begin errors++; $display("FAIL int_status: got %h want %h", d, 32'h9); end
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_F000; sel_i = 4'hF;
    #1;
    vectors++;
    if (data_o !== 32'h0000_0044) begin errors++; $display("FAIL int_data: got %h want %h", data_o, 32'h44); end
    @(negedge clk);
    ce_i = 1'b0;
    vectors++;
    if (int_o !== 1'b1) begin errors++; $display("FAIL int_hold: got %b want 1", int_o); end
    @(negedge clk);
    vectors++;
    if (int_o !== 1'b0) begin errors++; $display("FAIL int_drop: got %b want 0", int_o); end
  endtask

  task automatic test_miss_and_reset;
    logic [31:0] d;
    write_reg(32'h0000_F010, 32'hDEAD_BEEF, 4'b1111);
    vectors++;
    if (data_show_o !== 32'h1234_56FF || out_o !== 1'b0) begin
      errors++; $display("FAIL miss_write: got %h/%b want %h/0", data_show_o, out_o, 32'h123456FF);
    end
    read_reg(32'h0000_F010, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL miss_read: got %h want %h", d, 32'h0); end
    @(negedge clk);
    ce_i = 1'b0; we_i = 1'b1; addr_i = 32'h0000_F008; data_i = 32'hCAFE_F00D; sel_i = 4'hF;
    @(negedge clk);
    we_i = 1'b0;
    vectors++;
    if (data_show_o !== 32'h1234_56FF || out_o !== 1'b0) begin
      errors++; $display("FAIL noce_write: got %h/%b want %h/0", data_show_o, out_o, 32'h123456FF);
    end
    #1;
    vectors++;
    if (data_o !== 32'h0) begin errors++; $display("FAIL noce_read: got %h want %h", data_o, 32'h0); end
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_F004; data_i = 32'hFFFF_FFFF; sel_i = 4'hF;
    #1;
    vectors++;
    if (data_o !== 32'h0) begin errors++; $display("FAIL store_data_o: got %h want %h", data_o, 32'h0); end
    @(negedge clk);
    ce_i = 1'b0; we_i = 1'b0;
    read_reg(32'h0000_F004, d);
    vectors++;
    if (d !== 32'h8) begin errors++; $display("FAIL status_ro: got %h want %h", d, 32'h8); end
    data_show_i = 32'h0000_0055;
    @(negedge clk);
    enter = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    enter = 1'b0;
    #1;
    vectors++;
    if (data_show_o !== 32'h0 || out_o !== 1'b0 || int_o !== 1'b0) begin
      errors++; $display("FAIL midreset_outs: got %h/%b/%b want 0/0/0", data_show_o, out_o, int_o);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    read_reg(32'h0000_F004, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h want %h", d, 32'h0); end
    read_reg(32'h0000_F000, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h want %h", d, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_out_data();
    test_overrun();
    test_glitch_int();
    test_miss_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
